// File: rtl/ysyx_041461_exe_mem_buf.sv
// EXE -> MEM pipeline boundary: a two-entry buffer (main + skid).
// The main entry drives out_*. The skid entry absorbs one extra accept, so
// in_ready comes straight from a flop and MEM backpressure never reaches EXE
// combinationally.
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | nothing held; out_valid=0, in_ready=1
// ONE   | main entry valid; skid empty; in_ready=1
// FULL  | main and skid valid (skid is younger); in_ready=0
//
// The state encoding is chosen so that bit0 is main_v and bit1 is skid_v.
// As a result, out_valid and in_ready each come directly from one state flop.
module ysyx_041461_exe_mem_buf #(
  parameter int XLEN    = 64,
  parameter int MCTRL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_result,
  input  logic [XLEN-1:0]    in_sdata,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [4:0]         in_rd,
  input  logic               in_rd_wen,
  input  logic [MCTRL_W-1:0] in_mctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_sdata,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rd,
  output logic               out_rd_wen,
  output logic [MCTRL_W-1:0] out_mctrl
);

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    sdata;
    logic [XLEN-1:0]    pc;
    logic [4:0]         rd;
    logic               rd_wen;
    logic [MCTRL_W-1:0] mctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  entry_t head;
  logic   accept;
  logic   pop;

  assign in_entry = '{result: in_result, sdata: in_sdata, pc: in_pc,
                      rd: in_rd, rd_wen: in_rd_wen, mctrl: in_mctrl};

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next state and payload moves. The main entry is only rewritten when it is
  // empty or is being popped, so its payload stays stable while MEM stalls.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A pop in the same cycle as a flush still counts as consumed by MEM.
    // Everything else held or arriving this cycle is dropped.
    if (flush) state_d = EMPTY;
  end

  // State and entry registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Force the head payload to zero whenever there is no valid entry, so stale
  // register contents never appear on out_*.
  always_comb begin
    head = out_valid ? main_q : '0;
  end

  assign out_result = head.result;
  assign out_sdata  = head.sdata;
  assign out_pc     = head.pc;
  assign out_rd     = head.rd;
  assign out_rd_wen = head.rd_wen;
  assign out_mctrl  = head.mctrl;

endmodule

// File: tb/tb_ysyx_041461_exe_mem_buf.sv
// Directed bench for the EXE/MEM two-entry buffer.
module tb_ysyx_041461_exe_mem_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_result = '0;
  logic [63:0] in_sdata = '0;
  logic [63:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic [3:0]  in_mctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [63:0] out_sdata;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [3:0]  out_mctrl;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_041461_exe_mem_buf #(.XLEN(64), .MCTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_sdata(in_sdata), .in_pc(in_pc),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_mctrl(in_mctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sdata(out_sdata), .out_pc(out_pc),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_mctrl(out_mctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [63:0] res;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_res;
  } vec_t;

  vec_t vecs[18];

  // The side fields are derived from the result so that every field can be
  // checked in the table-driven section.
  function automatic logic [63:0] f_sdata(input logic [63:0] r); return ~r; endfunction
  function automatic logic [63:0] f_pc(input logic [63:0] r); return {r[31:0], r[63:32]}; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [63:0] r);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_result = r;
    in_sdata  = f_sdata(r);
    in_pc     = f_pc(r);
    in_rd     = r[4:0];
    in_rd_wen = r[0];
    in_mctrl  = r[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // iv ordy fl  res            e_ov e_ir e_res
    // stream
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h1,    1'b1, 1'b1, 64'h1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 64'h2,    1'b1, 1'b1, 64'h2};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'h3,    1'b1, 1'b1, 64'h3};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 1'b1, 64'h0};
    // backpressure: A, B fill, C held off, then drain in order
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'hA,    1'b1, 1'b1, 64'hA};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 64'hB,    1'b1, 1'b0, 64'hA};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'hC,    1'b1, 1'b0, 64'hA};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 64'hC,    1'b1, 1'b1, 64'hB};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 64'hC,    1'b1, 1'b1, 64'hC};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 1'b1, 64'h0};
    // flush from FULL with an incoming entry
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'hD,    1'b1, 1'b1, 64'hD};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 64'hE,    1'b1, 1'b0, 64'hD};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 64'hF,    1'b0, 1'b1, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 64'h55,   1'b1, 1'b1, 64'h55};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 1'b1, 64'h0};
    // invalid input with junk payload is ignored
    vecs[15] = '{1'b0, 1'b1, 1'b0, 64'hDEAD, 1'b0, 1'b1, 64'h0};
    // flush coinciding with a pop from ONE
    vecs[16] = '{1'b1, 1'b0, 1'b0, 64'h7,    1'b1, 1'b1, 64'h7};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 64'h0,    1'b0, 1'b1, 64'h0};

    // reset state
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_result", out_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].res);
      step();
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_out_result", i), out_result, vecs[i].e_res);
      chk($sformatf("v%0d_out_sdata", i), out_sdata, vecs[i].e_ov ? f_sdata(vecs[i].e_res) : 64'd0);
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_ov ? f_pc(vecs[i].e_res) : 64'd0);
      chk($sformatf("v%0d_out_rd", i), {59'd0, out_rd}, vecs[i].e_ov ? {59'd0, vecs[i].e_res[4:0]} : 64'd0);
      chk($sformatf("v%0d_out_mctrl", i), {60'd0, out_mctrl}, vecs[i].e_ov ? {60'd0, vecs[i].e_res[3:0]} : 64'd0);
    end

    // stall stability: FULL with MEM stalled for 5 cycles
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    in_result = 64'h100; in_pc = 64'h8000_0004; in_rd = 5'd5; in_mctrl = 4'd3;
    step();
    in_result = 64'h200; in_pc = 64'h8000_0008; in_rd = 5'd6; in_mctrl = 4'd1;
    step();
    in_result = 64'h300; in_pc = 64'h8000_000C; in_rd = 5'd7; in_mctrl = 4'd2;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall%0d_pc", c), out_pc, 64'h8000_0004);
      chk($sformatf("stall%0d_rd", c), {59'd0, out_rd}, 64'd5);
      chk($sformatf("stall%0d_mctrl", c), {60'd0, out_mctrl}, 64'd3);
      chk($sformatf("stall%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain_pc", out_pc, 64'h8000_0008);
    chk("drain_rd", {59'd0, out_rd}, 64'd6);
    step();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // field integrity
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 64'hA5A5_5A5A_DEAD_BEEF;
    in_sdata  = 64'hFFFF_FFFF_0000_0001;
    in_pc     = 64'hFFFF_FFFF_8000_0000;
    in_rd     = 5'd31;
    in_rd_wen = 1'b0;
    in_mctrl  = 4'hF;
    step();
    in_valid = 1'b0;
    chk("fld_result", out_result, 64'hA5A5_5A5A_DEAD_BEEF);
    chk("fld_sdata", out_sdata, 64'hFFFF_FFFF_0000_0001);
    chk("fld_pc", out_pc, 64'hFFFF_FFFF_8000_0000);
    chk("fld_rd", {59'd0, out_rd}, 64'd31);
    chk("fld_rd_wen", {63'd0, out_rd_wen}, 64'd0);
    chk("fld_mctrl", {60'd0, out_mctrl}, 64'hF);

    // async reset mid-cycle while an entry is valid
    chk("pre_arst_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_arst_valid", {63'd0, out_valid}, 64'd0);
    chk("post_arst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
